pe_mlane: RTL and testbench
===========================

// Module: pe_mlane
// PURPOSE
//  Next-gen PE: one kernel row of a 1-D conv for LANES output channels in parallel, sharing one ia stream.
//  Loads K*LANES weights (local row mem or left neighbour), forwards them right, emits LANES psums per output column upward.
//  Sits in the pe_array; PE columns stacked vertically via the psum chain form the full 2-D conv.
// PARAMETERS
//  INPUT_BW    8    ia/weight width, signed
//  PSUM_BW     32   psum width per lane, signed
//  LANES       4    parallel output channels (MACs)
//  KMAX        3    max kernel width (weight regs per lane)
//  IA_ADDR     7    ia row-mem address width
//  W_ADDR      8    weight row-mem address width
//  PSUM_ADDR   12   psum address width
// PORTS
//  clk                  in   1                 clock
//  reset                in   1                 async, active-high
//  start                in   1                 1-cycle pulse; cfg sampled here
//  cfg_k                in   3                 kernel width K
//  cfg_img_w            in   6                 output columns IMG_W
//  cfg_stride           in   3                 stride S
//  is_bottom            in   1                 1: psum_in treated as 0
//  w_src_local          in   1                 1: weights from row mem, else from left
//  busy / done          out  1                 busy=state!=IDLE; done=1-cycle pulse
//  ia_mem_addr/en       out  IA_ADDR/1         ia read; data 1 cycle after en
//  ia_mem_data          in   INPUT_BW          ia sample
//  w_mem_addr/en        out  W_ADDR/1          weight read; 1-cycle latency
//  w_mem_data           in   INPUT_BW          weight
//  left_w_data/valid    in   INPUT_BW/1        weight stream from left PE
//  right_w_data/valid   out  INPUT_BW/1        selected stream, registered 1 cycle
//  bot_psum_data        in   LANES*PSUM_BW     lane l at [l*PSUM_BW +: PSUM_BW]
//  bot_psum_addr/valid  in   PSUM_ADDR/1       from PE below
//  bot_psum_ready       out  1                 1-cycle pulse: bottom psum consumed
//  top_psum_data        out  LANES*PSUM_BW     to PE above / psum mem
//  top_psum_addr/valid  out  PSUM_ADDR/1       valid 1-cycle pulse
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, weight regs and accumulators 0. Reset mid-op aborts, no done.
//  cfg latched at start; K clamped to KMAX; start ignored while busy.
//  K==0 or IMG_W==0: IDLE->DONE, done next cycle, no mem access, no top_valid.
//  FSM: IDLE -start-> LOAD_W -> FETCH -> WAIT_PSUM -> EMIT -> (FETCH | DONE) -> IDLE.
//  LOAD_W: K*LANES weights, lane-major, index i=l*K+k. Local: w_mem_en on i=0..K*LANES-1,
//   data to w[l][k] 1 cycle later. Remote: each left_w_valid latches next index.
//   Exit once all K*LANES latched; right_w_* = registered selected stream, all states.
//  FETCH (col x): k=0..K-1 on K cycles, ia_mem_en=1, addr=x*S+k truncated to IA_ADDR;
//   acc[l] += ia*w[l][k] 1 cycle after each read, full-precision product sign-extended.
//  WAIT_PSUM: entered after last product accumulated. is_bottom: 1 cycle, psum=0, addr=x.
//   else hold until bot_psum_valid; then bot_psum_ready=1, psum=bot_psum_data, addr=bot_psum_addr.
//  EMIT: top_psum_data[l]=acc[l]+psum[l], top_valid=1 one cycle, acc cleared; x++.
//   x==IMG_W-1 -> DONE; DONE asserts done 1 cycle -> IDLE.
//  Bottom timing: K+2 cycles per column; top outputs hold last value when invalid.
//  bot_psum_valid outside WAIT_PSUM: ignored, not consumed; upstream holds it.
// CONFIGURATION
//  PE_SAT_EN defined: acc and psum add saturate to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
//  Undefined: two's-complement wrap at PSUM_BW. No other behaviour differs.
// TESTING
//  1 bottom, K=3,S=1,W=4, ia[n]=n+1, w[l][k]=l+1 -> lane l col0=6(l+1), col3=15(l+1); addr 0..3; done 1 cycle after last EMIT.
//  2 same, S=2,W=2 -> ia addrs 0,1,2 then 2,3,4; lane0 = 6, 12.
//  3 non-bottom, bot_psum 100 per lane, valid 3 cycles late -> FSM holds WAIT_PSUM, one ready pulse, top = 106.
//  4 w_src_local=0, 12 left weights 1 per cycle -> right_w mirrors 1 cycle late; no w_mem_en; LOAD_W exits after 12th.
//  5 K=1,w=127,ia=127, psum 0x7FFFFFF0 -> wraps 0x80003EF1 without PE_SAT_EN; 0x7FFFFFFF with it.
//  6 reset mid-FETCH -> outputs 0 same cycle, no done; start K=0 -> done next cycle, no en/valid.

Source files
------------

// File: rtl/pe_mlane.sv
// Multi-lane 1-D conv processing element: LANES output channels share one ia stream.
// Optional build macro PE_SAT_EN selects saturating accumulate/psum add instead of wrap.
module pe_mlane #(
  parameter int INPUT_BW  = 8,
  parameter int PSUM_BW   = 32,
  parameter int LANES     = 4,
  parameter int KMAX      = 3,
  parameter int IA_ADDR   = 7,
  parameter int W_ADDR    = 8,
  parameter int PSUM_ADDR = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 cfg_k,
  input  logic [5:0]                 cfg_img_w,
  input  logic [2:0]                 cfg_stride,
  input  logic                       is_bottom,
  input  logic                       w_src_local,
  output logic                       busy,
  output logic                       done,
  output logic [IA_ADDR-1:0]         ia_mem_addr,
  output logic                       ia_mem_en,
  input  logic [INPUT_BW-1:0]        ia_mem_data,
  output logic [W_ADDR-1:0]          w_mem_addr,
  output logic                       w_mem_en,
  input  logic [INPUT_BW-1:0]        w_mem_data,
  input  logic [INPUT_BW-1:0]        left_w_data,
  input  logic                       left_w_valid,
  output logic [INPUT_BW-1:0]        right_w_data,
  output logic                       right_w_valid,
  input  logic [LANES*PSUM_BW-1:0]   bot_psum_data,
  input  logic [PSUM_ADDR-1:0]       bot_psum_addr,
  input  logic                       bot_psum_valid,
  output logic                       bot_psum_ready,
  output logic [LANES*PSUM_BW-1:0]   top_psum_data,
  output logic [PSUM_ADDR-1:0]       top_psum_addr,
  output logic                       top_psum_valid
);

  localparam int NW  = LANES * KMAX;
  localparam int CW  = $clog2(NW + 1);
  localparam int WIX = $clog2(NW);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_FETCH, S_WAIT_PSUM, S_EMIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]          k_r, stride_r, fk, pend_k, k_clamp;
  logic [5:0]          img_w_r, x_cnt;
  logic                bottom_r, local_r, rd_valid_q, prod_pend;
  logic [CW-1:0]       issue_cnt, lat_cnt, n_w;
  logic [INPUT_BW-1:0] w_flat [NW];
  logic [PSUM_BW-1:0]  acc     [LANES];
  logic [PSUM_BW-1:0]  acc_upd [LANES];
  logic [PSUM_BW-1:0]  top_sum [LANES];
  logic                load_fire, psum_ok;
  logic [INPUT_BW-1:0] load_data;
  logic [IA_ADDR-1:0]  ia_addr_calc;
  logic [PSUM_ADDR-1:0] psum_addr_sel;
  logic signed [2*INPUT_BW-1:0] ia_ext;

  function automatic logic [PSUM_BW-1:0] psum_add(input logic [PSUM_BW-1:0] a,
                                                  input logic [PSUM_BW-1:0] b);
    logic [PSUM_BW-1:0] s;
    s = a + b;
`ifdef PE_SAT_EN
    if (a[PSUM_BW-1] == b[PSUM_BW-1] && s[PSUM_BW-1] != a[PSUM_BW-1])
      s = a[PSUM_BW-1] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
`endif
    return s;
  endfunction

  assign k_clamp   = (cfg_k > 3'(KMAX)) ? 3'(KMAX) : cfg_k;
  assign n_w       = CW'(k_r) * CW'(LANES);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign w_mem_en  = (state == S_LOAD_W) && local_r && (issue_cnt < n_w);
  assign w_mem_addr = w_mem_en ? W_ADDR'(issue_cnt) : '0;
  assign load_fire = (state == S_LOAD_W) && (local_r ? rd_valid_q : left_w_valid);
  assign load_data = local_r ? w_mem_data : left_w_data;
  // ia address wraps modulo the row-memory depth
  assign ia_addr_calc = IA_ADDR'(x_cnt) * IA_ADDR'(stride_r) + IA_ADDR'(fk);
  assign ia_mem_en   = (state == S_FETCH);
  assign ia_mem_addr = ia_mem_en ? ia_addr_calc : '0;
  assign psum_ok        = bottom_r || bot_psum_valid;
  assign bot_psum_ready = (state == S_WAIT_PSUM) && !bottom_r && bot_psum_valid;
  assign psum_addr_sel  = bottom_r ? PSUM_ADDR'(x_cnt) : bot_psum_addr;
  assign ia_ext = {{INPUT_BW{ia_mem_data[INPUT_BW-1]}}, ia_mem_data};

  // Weights are stored lane-major (l*K+k), so the read index depends on the latched K.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIX-1:0]               widx;
    logic [INPUT_BW-1:0]          w_sel;
    logic signed [2*INPUT_BW-1:0] w_ext, prod;
    logic [PSUM_BW-1:0]           psum_sel;
    assign widx     = WIX'(l) * WIX'(k_r) + WIX'(pend_k);
    assign w_sel    = w_flat[widx];
    assign w_ext    = {{INPUT_BW{w_sel[INPUT_BW-1]}}, w_sel};
    assign prod     = ia_ext * w_ext;
    assign psum_sel = bottom_r ? '0 : bot_psum_data[l*PSUM_BW +: PSUM_BW];
    assign acc_upd[l] = prod_pend
      ? psum_add(acc[l], {{(PSUM_BW-2*INPUT_BW){prod[2*INPUT_BW-1]}}, prod})
      : acc[l];
    assign top_sum[l] = psum_add(acc_upd[l], psum_sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = (cfg_k == 3'd0 || cfg_img_w == 6'd0) ? S_DONE : S_LOAD_W;
      S_LOAD_W:    if (load_fire && lat_cnt == n_w - CW'(1)) state_nxt = S_FETCH;
      S_FETCH:     if (fk == k_r - 3'd1) state_nxt = S_WAIT_PSUM;
      S_WAIT_PSUM: if (psum_ok) state_nxt = S_EMIT;
      S_EMIT:      state_nxt = (x_cnt == img_w_r - 6'd1) ? S_DONE : S_FETCH;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Products land one cycle after each ia read; the last one is folded in while in WAIT_PSUM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r <= '0; stride_r <= '0; img_w_r <= '0; bottom_r <= 1'b0; local_r <= 1'b0;
      issue_cnt <= '0; lat_cnt <= '0; fk <= '0; pend_k <= '0; x_cnt <= '0;
      rd_valid_q <= 1'b0; prod_pend <= 1'b0;
      right_w_data <= '0; right_w_valid <= 1'b0;
      top_psum_data <= '0; top_psum_addr <= '0; top_psum_valid <= 1'b0;
      for (int i = 0; i < NW; i++) w_flat[i] <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      rd_valid_q     <= w_mem_en;
      prod_pend      <= ia_mem_en;
      pend_k         <= fk;
      right_w_valid  <= w_src_local ? rd_valid_q : left_w_valid;
      right_w_data   <= w_src_local ? w_mem_data : left_w_data;
      top_psum_valid <= 1'b0;
      for (int l = 0; l < LANES; l++) acc[l] <= acc_upd[l];
      case (state)
        S_IDLE: if (start) begin
          k_r <= k_clamp; stride_r <= cfg_stride; img_w_r <= cfg_img_w;
          bottom_r <= is_bottom; local_r <= w_src_local;
          issue_cnt <= '0; lat_cnt <= '0; fk <= '0; x_cnt <= '0;
          for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end
        S_LOAD_W: begin
          if (w_mem_en) issue_cnt <= issue_cnt + CW'(1);
          if (load_fire) begin
            w_flat[WIX'(lat_cnt)] <= load_data;
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        S_FETCH: fk <= (fk == k_r - 3'd1) ? 3'd0 : fk + 3'd1;
        S_WAIT_PSUM: if (psum_ok) begin
          for (int l = 0; l < LANES; l++) begin
            top_psum_data[l*PSUM_BW +: PSUM_BW] <= top_sum[l];
            acc[l] <= '0;
          end
          top_psum_addr  <= psum_addr_sel;
          top_psum_valid <= 1'b1;
        end
        S_EMIT: x_cnt <= x_cnt + 6'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mlane.sv
// Self-checking bench for pe_mlane: arithmetic model of the conv row plus directed literal checks.
module tb_pe_mlane;
  localparam int LANES = 4;
  localparam int PSUM_BW = 32;

  logic clk, reset, start, is_bottom, w_src_local;
  logic [2:0] cfg_k, cfg_stride;
  logic [5:0] cfg_img_w;
  logic busy, done, ia_mem_en, w_mem_en, left_w_valid, right_w_valid;
  logic [6:0] ia_mem_addr;
  logic [7:0] w_mem_addr, ia_mem_data, w_mem_data, left_w_data, right_w_data;
  logic [LANES*PSUM_BW-1:0] bot_psum_data, top_psum_data;
  logic [11:0] bot_psum_addr, top_psum_addr;
  logic bot_psum_valid, bot_psum_ready, top_psum_valid;

  pe_mlane dut (
    .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .cfg_img_w(cfg_img_w),
    .cfg_stride(cfg_stride), .is_bottom(is_bottom), .w_src_local(w_src_local),
    .busy(busy), .done(done), .ia_mem_addr(ia_mem_addr), .ia_mem_en(ia_mem_en),
    .ia_mem_data(ia_mem_data), .w_mem_addr(w_mem_addr), .w_mem_en(w_mem_en),
    .w_mem_data(w_mem_data), .left_w_data(left_w_data), .left_w_valid(left_w_valid),
    .right_w_data(right_w_data), .right_w_valid(right_w_valid),
    .bot_psum_data(bot_psum_data), .bot_psum_addr(bot_psum_addr),
    .bot_psum_valid(bot_psum_valid), .bot_psum_ready(bot_psum_ready),
    .top_psum_data(top_psum_data), .top_psum_addr(top_psum_addr),
    .top_psum_valid(top_psum_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ia_arr [128];
  logic [7:0] w_arr  [256];
  int wt [4][3];
  always @(posedge clk) begin
    if (ia_mem_en) ia_mem_data <= ia_arr[ia_mem_addr];
    if (w_mem_en)  w_mem_data  <= w_arr[w_mem_addr];
  end

  typedef struct { logic [127:0] data; logic [11:0] addr; } exp_t;
  exp_t exp_q[$];
  logic [127:0] obs_data[$];
  logic [11:0]  obs_addr[$];
  int top_cyc[$], ia_log[$];
  int top_cnt, ready_cnt, w_en_cnt, done_cnt = 0, done_cyc, first_ia_cyc, start_cyc, last_w_cyc;
  int done_base, wait_age = -1, prov_delay;
  bit prov_en = 0, ready_seen = 0, mirror_en = 0, prev_ia_en_n = 0;
  logic prev_lv;
  logic [7:0] prev_ld;
  always @(posedge clk) begin
    prev_lv <= left_w_valid;
    prev_ld <= left_w_data;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic longint add32(input longint a, input longint b);
    longint s = a + b;
`ifdef PE_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
    s = longint'($signed(32'(s)));
`endif
    return s;
  endfunction

  // Compare process: every top_psum_valid pulse is matched against the model queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (top_psum_valid) begin
        top_cnt++;
        top_cyc.push_back(cyc);
        obs_data.push_back(top_psum_data);
        obs_addr.push_back(top_psum_addr);
        if (exp_q.size() == 0) checkOutput("unexpected_top", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          checkOutput("top_data", top_psum_data, e.data);
          checkOutput("top_addr", top_psum_addr, e.addr);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (ia_mem_en) begin
        ia_log.push_back(int'(ia_mem_addr));
        if (first_ia_cyc < 0) first_ia_cyc = cyc;
      end
      if (w_mem_en) w_en_cnt++;
      if (bot_psum_ready) begin ready_cnt++; ready_seen = 1; end
      if (prev_ia_en_n && !ia_mem_en) wait_age = 0;
      else if (wait_age >= 0) wait_age++;
      prev_ia_en_n = ia_mem_en;
      if (mirror_en) begin
        checkOutput("right_w_valid", right_w_valid, prev_lv);
        if (prev_lv) checkOutput("right_w_data", right_w_data, prev_ld);
      end
    end
  end

  // Upstream PE model: raises valid (early or some cycles into the wait) and holds it until ready.
  initial begin : provider
    bot_psum_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bot_psum_valid && ready_seen) begin
        bot_psum_valid = 1'b0;
        bot_psum_addr  = bot_psum_addr + 12'd1;
        ready_seen = 0;
        wait_age = -1;
      end else if (prov_en && !bot_psum_valid && (prov_delay < 0 || wait_age >= prov_delay))
        bot_psum_valid = 1'b1;
    end
  end

  task automatic applyStimulus(input int k, input int w, input int s, input bit bottom,
                               input bit loc, input int pdelay, input logic [31:0] pval);
    int keff;
    longint acc, top;
    exp_t e;
    keff = (k > 3) ? 3 : k;
    if (keff > 0 && w > 0)
      for (int x = 0; x < w; x++) begin
        e.data = '0;
        for (int l = 0; l < LANES; l++) begin
          acc = 0;
          for (int kk = 0; kk < keff; kk++)
            acc = add32(acc, longint'($signed(ia_arr[(x*s+kk) % 128])) * longint'(wt[l][kk]));
          top = add32(acc, bottom ? 64'sd0 : longint'($signed(pval)));
          e.data[l*32 +: 32] = 32'(top);
        end
        e.addr = bottom ? 12'(x) : 12'(12'h100 + x);
        exp_q.push_back(e);
      end
    for (int l = 0; l < LANES; l++)
      for (int kk = 0; kk < keff; kk++) w_arr[l*keff + kk] = 8'(wt[l][kk]);
    top_cnt = 0; ready_cnt = 0; w_en_cnt = 0; done_cyc = -1; first_ia_cyc = -1;
    ia_log.delete(); top_cyc.delete(); obs_data.delete(); obs_addr.delete();
    bot_psum_data = {4{pval}};
    bot_psum_addr = 12'h100;
    prov_delay = pdelay; wait_age = -1; ready_seen = 0; prov_en = !bottom;
    done_base = done_cnt;
    @(posedge clk); #1;
    cfg_k = 3'(k); cfg_img_w = 6'(w); cfg_stride = 3'(s);
    is_bottom = bottom; w_src_local = loc; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (!loc)
      for (int i = 0; i < keff*LANES; i++) begin
        left_w_valid = 1'b1;
        left_w_data = 8'(wt[i/keff][i%keff]);
        last_w_cyc = cyc;
        @(posedge clk); #1;
      end
    left_w_valid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (done_cnt == done_base && n < 4000) begin @(negedge clk); n++; end
    checkOutput({name, "_done_seen"}, 1'(done_cnt > done_base), 1'b1);
    repeat (3) @(negedge clk);
    prov_en = 0;
    bot_psum_valid = 1'b0;
    checkOutput({name, "_done_pulses"}, done_cnt - done_base, 1);
    checkOutput({name, "_tops_drained"}, exp_q.size(), 0);
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, "_busy"}, busy, 1'b0);
    checkOutput({name, "_done"}, done, 1'b0);
    checkOutput({name, "_ia_en"}, ia_mem_en, 1'b0);
    checkOutput({name, "_w_en"}, w_mem_en, 1'b0);
    checkOutput({name, "_top_valid"}, top_psum_valid, 1'b0);
    checkOutput({name, "_top_data"}, top_psum_data, '0);
    checkOutput({name, "_right_valid"}, right_w_valid, 1'b0);
    checkOutput({name, "_ready"}, bot_psum_ready, 1'b0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    logic [127:0] od;
    int exp_ia [6] = '{0, 1, 2, 2, 3, 4};
    reset = 1'b1; start = 1'b0; cfg_k = '0; cfg_img_w = '0; cfg_stride = '0;
    is_bottom = 1'b1; w_src_local = 1'b1; left_w_valid = 1'b0; left_w_data = '0;
    bot_psum_data = '0; bot_psum_addr = '0;
    for (int n = 0; n < 128; n++) ia_arr[n] = 8'(n + 1);
    for (int n = 0; n < 256; n++) w_arr[n] = '0;
    repeat (3) @(negedge clk);
    checkQuiet("reset");
    @(posedge clk); #1 reset = 1'b0;

    // 1: bottom, K=3 S=1 W=4, w[l][k]=l+1
    for (int l = 0; l < 4; l++) for (int k = 0; k < 3; k++) wt[l][k] = l + 1;
    applyStimulus(3, 4, 1, 1, 1, -1, 32'd0);
    waitDone("t1");
    checkOutput("t1_w_en_count", w_en_cnt, 12);
    if (obs_data.size() == 4) begin
      for (int l = 0; l < 4; l++) begin
        od = obs_data[0]; checkOutput("t1_col0", od[l*32 +: 32], 32'(6*(l+1)));
        od = obs_data[3]; checkOutput("t1_col3", od[l*32 +: 32], 32'(15*(l+1)));
      end
      for (int i = 0; i < 4; i++) checkOutput("t1_addr", obs_addr[i], 12'(i));
      checkOutput("t1_col_spacing", top_cyc[1] - top_cyc[0], 5);
      checkOutput("t1_done_after_emit", done_cyc, top_cyc[3] + 1);
    end else checkOutput("t1_top_count", obs_data.size(), 4);

    // 2: stride 2, two columns
    applyStimulus(3, 2, 2, 1, 1, -1, 32'd0);
    waitDone("t2");
    if (ia_log.size() == 6) for (int i = 0; i < 6; i++) checkOutput("t2_ia_addr", ia_log[i], exp_ia[i]);
    else checkOutput("t2_ia_count", ia_log.size(), 6);
    if (obs_data.size() == 2) begin
      od = obs_data[0]; checkOutput("t2_lane0_col0", od[31:0], 32'd6);
      od = obs_data[1]; checkOutput("t2_lane0_col1", od[31:0], 32'd12);
    end else checkOutput("t2_top_count", obs_data.size(), 2);

    // 3: non-bottom, psum arrives late
    applyStimulus(3, 2, 1, 0, 1, 3, 32'd100);
    waitDone("t3");
    checkOutput("t3_ready_pulses", ready_cnt, 2);
    if (obs_data.size() == 2) begin
      od = obs_data[0]; checkOutput("t3_lane0", od[31:0], 32'd106);
      checkOutput("t3_addr", obs_addr[0], 12'h100);
      checkOutput("t3_held_in_wait", 1'(top_cyc[0] - first_ia_cyc > 4), 1'b1);
    end else checkOutput("t3_top_count", obs_data.size(), 2);

    // 5: overflow of final psum add; psum valid held from the start
    for (int l = 0; l < 4; l++) wt[l][0] = 127;
    ia_arr[0] = 8'd127;
    applyStimulus(1, 1, 1, 0, 1, -1, 32'h7FFF_FFF0);
    waitDone("t5");
    checkOutput("t5_ready_pulses", ready_cnt, 1);
    if (obs_data.size() == 1) begin
      od = obs_data[0];
`ifdef PE_SAT_EN
      checkOutput("t5_sat", od[31:0], 32'h7FFF_FFFF);
`else
      checkOutput("t5_wrap", od[31:0], 32'h8000_3EF1);
`endif
    end else checkOutput("t5_top_count", obs_data.size(), 1);
    ia_arr[0] = 8'd1;

    // 4: weights streamed from the left neighbour
    for (int l = 0; l < 4; l++) for (int k = 0; k < 3; k++) wt[l][k] = l*3 + k + 1;
    w_src_local = 1'b0;
    @(posedge clk); #1 mirror_en = 1;
    applyStimulus(3, 2, 1, 1, 0, -1, 32'd0);
    waitDone("t4");
    mirror_en = 0;
    checkOutput("t4_no_w_en", w_en_cnt, 0);
    checkOutput("t4_load_exit", first_ia_cyc, last_w_cyc + 1);
    if (obs_data.size() == 2) begin
      od = obs_data[0];
      checkOutput("t4_lane0", od[31:0], 32'd14);
      checkOutput("t4_lane3", od[127:96], 32'd68);
    end else checkOutput("t4_top_count", obs_data.size(), 2);

    // 6: degenerate configs finish immediately
    applyStimulus(0, 4, 1, 1, 1, -1, 32'd0);
    waitDone("t6k0");
    checkOutput("t6k0_done_next", done_cyc, start_cyc + 1);
    checkOutput("t6k0_no_ia", ia_log.size(), 0);
    checkOutput("t6k0_no_w", w_en_cnt, 0);
    checkOutput("t6k0_no_top", top_cnt, 0);
    applyStimulus(3, 0, 1, 1, 1, -1, 32'd0);
    waitDone("t6w0");
    checkOutput("t6w0_done_next", done_cyc, start_cyc + 1);
    checkOutput("t6w0_no_ia", ia_log.size(), 0);

    // 6: reset during FETCH
    applyStimulus(3, 4, 1, 1, 1, -1, 32'd0);
    begin
      int n = 0;
      while (first_ia_cyc < 0 && n < 200) begin @(negedge clk); n++; end
    end
    checkOutput("t6_reached_fetch", 1'(first_ia_cyc >= 0), 1'b1);
    done_base = done_cnt;
    @(posedge clk); #1 reset = 1'b1;
    #1 checkQuiet("t6_midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t6_no_done", done_cnt - done_base, 0);
    checkOutput("t6_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
